// File: rtl/vga_stream_capture_pkg.sv
// Shared constants, capture FSM states and pixel truncation for the VGA stream capture sink.
// The address width is derived from the frame-buffer size.
package vga_stream_pkg;

    localparam int VGA_WIDTH     = 640;
    localparam int VGA_HEIGHT    = 480;
    localparam int SCALE_LOG2    = 2;
    localparam int SRC_WIDTH     = VGA_WIDTH >> SCALE_LOG2;
    localparam int SRC_HEIGHT    = VGA_HEIGHT >> SCALE_LOG2;
    localparam int NumPixels     = SRC_WIDTH * SRC_HEIGHT;
    localparam int NumColourBits = 12;
    localparam int AddrBits      = $clog2(NumPixels);

    typedef enum logic [1:0] {
        WAIT_SOP = 2'd0,
        RECEIVE  = 2'd1,
        RESYNC   = 2'd2
    } cap_state_t;

    // Keep the top 4 bits of each 10-bit channel: {R, G, B}.
    function automatic logic [NumColourBits-1:0] truncate_pixel(input logic [29:0] pix);
        return {pix[29:26], pix[19:16], pix[9:6]};
    endfunction

endpackage

// File: rtl/vga_stream_capture_pos_counter.sv
// Raster position tracker for the capture sink: x/y counters with clear, start and advance.
// The start operation places the counter on pixel 1, because the SOP beat itself is pixel 0.
module vga_pos_counter #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int SCALE_LOG2 = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clear_i,
    input  logic       start_i,
    input  logic       advance_i,
    output logic [9:0] x_o,
    output logic [8:0] y_o,
    output logic       last_pixel_o,
    output logic       on_grid_o
);

    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       x_at_end;
    logic       y_at_end;

    assign x_at_end = (x_q == 10'(WIDTH - 1));
    assign y_at_end = (y_q == 9'(HEIGHT - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (start_i) begin
            x_d = 10'd1;
            y_d = '0;
        end else if (advance_i) begin
            if (x_at_end) begin
                x_d = '0;
                y_d = y_at_end ? '0 : y_q + 9'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o          = x_q;
    assign y_o          = y_q;
    assign last_pixel_o = x_at_end && y_at_end;
    assign on_grid_o    = (x_q[SCALE_LOG2-1:0] == '0) && (y_q[SCALE_LOG2-1:0] == '0);

endmodule

// File: rtl/vga_stream_capture.sv
// Avalon-ST video sink: checks SOP/EOP framing, decimates the raster and writes a 12-bit buffer.
// Handshake: a beat moves on a cycle where valid && ready; ready is simply ~reset (no back-pressure).
module vga_stream_capture #(
    parameter int VGA_WIDTH  = vga_stream_pkg::VGA_WIDTH,
    parameter int VGA_HEIGHT = vga_stream_pkg::VGA_HEIGHT,
    parameter int SCALE_LOG2 = vga_stream_pkg::SCALE_LOG2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] data,
    input  logic        startofpacket,
    input  logic        endofpacket,
    input  logic        valid,
    output logic        ready,
    input  logic        capture_en,
    input  logic        err_clear,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [11:0] wr_data,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        err_early_eop,
    output logic        err_missing_eop,
    output logic        err_sop_mid,
    output logic [1:0]  dbg_state
);

    import vga_stream_pkg::*;

    localparam int DST_WIDTH = VGA_WIDTH >> SCALE_LOG2;

    cap_state_t               state_q, state_d;
    logic                     cap_q, cap_d;
    logic                     wr_en_q, wr_en_d;
    logic [AddrBits-1:0]      wr_addr_q, wr_addr_d;
    logic [NumColourBits-1:0] wr_data_q, wr_data_d;
    logic                     done_q, done_d;
    logic [15:0]              count_q, count_d;
    logic                     early_q, missing_q, sop_mid_q;
    logic                     set_early, set_missing, set_sop_mid;

    logic                     accept;
    logic                     pos_clear, pos_start, pos_advance;
    logic [9:0]               pos_x;
    logic [8:0]               pos_y;
    logic                     last_pixel, on_grid;
    logic [AddrBits-1:0]      pix_addr;

    vga_pos_counter #(
        .WIDTH      (VGA_WIDTH),
        .HEIGHT     (VGA_HEIGHT),
        .SCALE_LOG2 (SCALE_LOG2)
    ) u_pos (
        .clk_i        (clk),
        .reset_i      (reset),
        .clear_i      (pos_clear),
        .start_i      (pos_start),
        .advance_i    (pos_advance),
        .x_o          (pos_x),
        .y_o          (pos_y),
        .last_pixel_o (last_pixel),
        .on_grid_o    (on_grid)
    );

    assign ready    = ~reset;
    assign accept   = valid && ready;
    assign pix_addr = AddrBits'((int'(pos_y) >> SCALE_LOG2) * DST_WIDTH
                                + (int'(pos_x) >> SCALE_LOG2));

    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        count_d     = count_q;
        set_early   = 1'b0;
        set_missing = 1'b0;
        set_sop_mid = 1'b0;
        pos_clear   = 1'b0;
        pos_start   = 1'b0;
        pos_advance = 1'b0;

        if (accept) begin
            if (startofpacket) begin
                // SOP always restarts at pixel 0; an EOP on the same beat is then an early end.
                set_sop_mid = (state_q == RECEIVE);
                cap_d       = capture_en;
                if (capture_en) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = truncate_pixel(data);
                end
                if (endofpacket) begin
                    set_early = 1'b1;
                    state_d   = WAIT_SOP;
                    pos_clear = 1'b1;
                end else begin
                    state_d   = RECEIVE;
                    pos_start = 1'b1;
                end
            end else begin
                case (state_q)
                    RECEIVE: begin
                        if (cap_q && on_grid) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = pix_addr;
                            wr_data_d = truncate_pixel(data);
                        end
                        if (last_pixel) begin
                            pos_clear = 1'b1;
                            if (endofpacket) begin
                                count_d = count_q + 16'd1;
                                done_d  = cap_q;
                                state_d = WAIT_SOP;
                            end else begin
                                set_missing = 1'b1;
                                state_d     = RESYNC;
                            end
                        end else if (endofpacket) begin
                            set_early = 1'b1;
                            state_d   = WAIT_SOP;
                            pos_clear = 1'b1;
                        end else begin
                            pos_advance = 1'b1;
                        end
                    end
                    RESYNC: begin
                        if (endofpacket) begin
                            state_d = WAIT_SOP;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WAIT_SOP;
            cap_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            count_q   <= '0;
            early_q   <= 1'b0;
            missing_q <= 1'b0;
            sop_mid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            count_q   <= count_d;
            // Clear wins over a same-cycle set, so that cycle's new error is dropped.
            early_q   <= err_clear ? 1'b0 : (early_q   | set_early);
            missing_q <= err_clear ? 1'b0 : (missing_q | set_missing);
            sop_mid_q <= err_clear ? 1'b0 : (sop_mid_q | set_sop_mid);
        end
    end

    assign wr_en           = wr_en_q;
    assign wr_addr         = wr_addr_q;
    assign wr_data         = wr_data_q;
    assign frame_done      = done_q;
    assign frame_count     = count_q;
    assign err_early_eop   = early_q;
    assign err_missing_eop = missing_q;
    assign err_sop_mid     = sop_mid_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_vga_stream_capture.sv
// Self-checking bench for vga_stream_capture on a reduced 32x16 raster (8x4 buffer).
// Frame scenarios come from a record table; framing corner cases are hand-written sequences.
`timescale 1ns/1ps
module tb_vga_stream_capture;

    localparam int W    = 32;
    localparam int H    = 16;
    localparam int S    = 2;
    localparam int DW   = W >> S;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] data;
    logic        startofpacket, endofpacket, valid;
    logic        ready;
    logic        capture_en, err_clear;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        err_early_eop, err_missing_eop, err_sop_mid;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    vga_stream_capture #(
        .VGA_WIDTH  (W),
        .VGA_HEIGHT (H),
        .SCALE_LOG2 (S)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .data            (data),
        .startofpacket   (startofpacket),
        .endofpacket     (endofpacket),
        .valid           (valid),
        .ready           (ready),
        .capture_en      (capture_en),
        .err_clear       (err_clear),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .frame_done      (frame_done),
        .frame_count     (frame_count),
        .err_early_eop   (err_early_eop),
        .err_missing_eop (err_missing_eop),
        .err_sop_mid     (err_sop_mid),
        .dbg_state       (dbg_state)
    );

    int          n_vec  = 0;
    int          n_miss = 0;
    int          done_seen = 0;
    logic [15:0] exp_count = '0;
    logic [26:0] exp_q[$];
    logic        prev_valid = 1'b0;

    typedef struct {
        string      name;
        int         nbeats;
        bit         cap;
        bit         eop_last;
        bit         rand_valid;
        bit         junk_after;
        int         exp_count_inc;
        int         exp_done;
        logic [2:0] exp_errs;   // {early, missing, sop_mid}
        logic [1:0] exp_state;
    } frame_vec_t;

    frame_vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] pix(input int i);
        logic [31:0] t;
        t = 32'(i) * 32'h0009_3A5B + 32'h0000_1234;
        return t[29:0];
    endfunction

    function automatic logic [11:0] trunc12(input logic [29:0] p);
        return {p[29:26], p[19:16], p[9:6]};
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic beat(input logic [29:0] d, input bit sop, input bit eop, input bit cap,
                        input bit rv);
        int idle;
        idle = rv ? int'($urandom_range(1, 0)) : 0;
        repeat (idle) begin
            valid = 1'b0;
            @(posedge clk);
            #1;
        end
        data          = d;
        startofpacket = sop;
        endofpacket   = eop;
        capture_en    = cap;
        valid         = 1'b1;
        @(posedge clk);
        #1;
        valid         = 1'b0;
        startofpacket = 1'b0;
        endofpacket   = 1'b0;
    endtask

    // capture_en is forced to 1 for the second half so a late enable must not start writes.
    task automatic send_frame(input int nbeats, input bit cap, input bit eop_last, input bit rv);
        for (int i = 0; i < nbeats; i++) begin
            int x;
            int y;
            x = i % W;
            y = i / W;
            if (cap && (x % (1 << S) == 0) && (y % (1 << S) == 0))
                exp_q.push_back({15'((y >> S) * DW + (x >> S)), trunc12(pix(i))});
            beat(pix(i), i == 0, eop_last && (i == nbeats - 1), (i < nbeats / 2) ? cap : 1'b1, rv);
        end
    endtask

    task automatic clear_errors();
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        settle(1);
        check("errs_after_clear", 32'({err_early_eop, err_missing_eop, err_sop_mid}), 32'd0);
    endtask

    always @(posedge clk) prev_valid <= valid;

    // Write scoreboard: every write must follow an accepted beat and match the queue head.
    always @(negedge clk) begin
        if (wr_en) begin
            check("wr_follows_beat", 32'(prev_valid), 32'd1);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write",
                         wr_addr, wr_data);
            end else begin
                logic [26:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[26:12]));
                check("wr_data", 32'(wr_data), 32'(e[11:0]));
            end
        end
        if (frame_done) done_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_before;

        reset = 1'b1;
        valid = 1'b0;
        data = '0;
        startofpacket = 1'b0;
        endofpacket = 1'b0;
        capture_en = 1'b0;
        err_clear = 1'b0;

        vecs[0] = '{"clean",          NPIX, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 3'b000, 2'd0};
        vecs[1] = '{"clean_rand",     NPIX, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 3'b000, 2'd0};
        vecs[2] = '{"early_eop",      100,  1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 3'b100, 2'd0};
        vecs[3] = '{"after_early",    NPIX, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 3'b000, 2'd0};
        vecs[4] = '{"missing_eop",    NPIX, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 3'b010, 2'd0};
        vecs[5] = '{"after_missing",  NPIX, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 3'b000, 2'd0};
        vecs[6] = '{"partial",        50,   1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3'b000, 2'd1};
        vecs[7] = '{"sop_restart",    NPIX, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 3'b001, 2'd0};
        vecs[8] = '{"capture_off",    NPIX, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 3'b000, 2'd0};
        vecs[9] = '{"capture_off_rv", NPIX, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 3'b000, 2'd0};

        // Reset values
        settle(3);
        check("rst_ready",   32'(ready), 32'd0);
        check("rst_wr_en",   32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_done",    32'(frame_done), 32'd0);
        check("rst_count",   32'(frame_count), 32'd0);
        check("rst_errs",    32'({err_early_eop, err_missing_eop, err_sop_mid}), 32'd0);
        check("rst_state",   32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        settle(1);
        check("ready_after_reset", 32'(ready), 32'd1);

        for (int v = 0; v < 10; v++) begin
            done_before = done_seen;
            send_frame(vecs[v].nbeats, vecs[v].cap, vecs[v].eop_last, vecs[v].rand_valid);
            if (vecs[v].junk_after) begin
                settle(1);
                check({vecs[v].name, "_resync_state"}, 32'(dbg_state), 32'd2);
                for (int j = 0; j < 5; j++) beat(pix(1000 + j), 1'b0, 1'b0, 1'b1, 1'b0);
                beat(pix(2000), 1'b0, 1'b1, 1'b1, 1'b0);
            end
            settle(2);
            exp_count = exp_count + 16'(vecs[v].exp_count_inc);
            check({vecs[v].name, "_count"}, 32'(frame_count), 32'(exp_count));
            check({vecs[v].name, "_done"}, 32'(done_seen - done_before), 32'(vecs[v].exp_done));
            check({vecs[v].name, "_errs"},
                  32'({err_early_eop, err_missing_eop, err_sop_mid}), 32'(vecs[v].exp_errs));
            check({vecs[v].name, "_state"}, 32'(dbg_state), 32'(vecs[v].exp_state));
            check({vecs[v].name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
            clear_errors();
        end

        // err_clear in the same cycle as an early EOP: the new error is lost
        done_before = done_seen;
        beat(pix(1), 1'b1, 1'b0, 1'b0, 1'b0);
        err_clear = 1'b1;
        beat(pix(2), 1'b0, 1'b1, 1'b0, 1'b0);
        err_clear = 1'b0;
        settle(1);
        check("clear_prio_errs",  32'({err_early_eop, err_missing_eop, err_sop_mid}), 32'd0);
        check("clear_prio_state", 32'(dbg_state), 32'd0);
        check("clear_prio_count", 32'(frame_count), 32'(exp_count));

        // SOP and EOP on one beat: pixel 0 written, then an early end
        exp_q.push_back({15'd0, trunc12(pix(7))});
        beat(pix(7), 1'b1, 1'b1, 1'b1, 1'b0);
        settle(1);
        check("sop_eop_errs",  32'({err_early_eop, err_missing_eop, err_sop_mid}), 32'b100);
        check("sop_eop_state", 32'(dbg_state), 32'd0);
        check("sop_eop_count", 32'(frame_count), 32'(exp_count));
        settle(1);
        check("sop_eop_done",   32'(done_seen - done_before), 32'd0);
        check("sop_eop_writes", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a captured frame
        send_frame(100, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        settle(1);
        check("midrst_ready",   32'(ready), 32'd0);
        check("midrst_wr_en",   32'(wr_en), 32'd0);
        check("midrst_wr_addr", 32'(wr_addr), 32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'd0);
        check("midrst_done",    32'(frame_done), 32'd0);
        check("midrst_count",   32'(frame_count), 32'd0);
        check("midrst_errs",    32'({err_early_eop, err_missing_eop, err_sop_mid}), 32'd0);
        check("midrst_state",   32'(dbg_state), 32'd0);
        check("midrst_writes",  32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_count = '0;

        done_before = done_seen;
        send_frame(NPIX, 1'b1, 1'b1, 1'b1);
        settle(2);
        check("post_rst_count",  32'(frame_count), 32'd1);
        check("post_rst_done",   32'(done_seen - done_before), 32'd1);
        check("post_rst_errs",   32'({err_early_eop, err_missing_eop, err_sop_mid}), 32'd0);
        check("post_rst_writes", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vga_stream_capture.md
Name: vga_stream_capture

Overview:
Avalon-ST video sink: the receiving end of the 640x480 30-bit pixel stream produced by the VGA face/filter source.
- Accepts pixels under valid/ready and checks packet framing (startofpacket/endofpacket).
- Decimates 4x in each axis (keeps the top-left pixel of every 4x4 block).
- Truncates each channel to 4 bits and writes a 160x120 12-bit frame buffer, so filtered frames can be read back or verified on-chip.

Parameters:
- VGA_WIDTH, 640, input frame width in pixels
- VGA_HEIGHT, 480, input frame height in pixels
- SCALE_LOG2, 2, decimation shift (factor 4 per axis)
- DST_WIDTH, VGA_WIDTH>>SCALE_LOG2, buffer width (160)
- DST_HEIGHT, VGA_HEIGHT>>SCALE_LOG2, buffer height (120)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- data  in  30  pixel {R[29:20],G[19:10],B[9:0]}
- startofpacket  in  1  first pixel of frame
- endofpacket  in  1  last pixel of frame
- valid  in  1  source has a beat
- ready  out  1  sink accepts a beat
- capture_en  in  1  arm capture; sampled on each accepted SOP beat
- err_clear  in  1  clears sticky error flags
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  15  buffer address, dst_y*DST_WIDTH + dst_x
- wr_data  out  12  {R[29:26],G[19:16],B[9:6]}
- frame_done  out  1  one-cycle pulse on each correctly framed captured frame
- frame_count  out  16  count of correctly framed frames received (captured or not); wraps
- err_early_eop  out  1  sticky: EOP before the last pixel
- err_missing_eop  out  1  sticky: last pixel without EOP
- err_sop_mid  out  1  sticky: SOP inside a frame

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: ready=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_count=0, all error flags 0, state=WAIT_SOP, x=y=0.
- Handshake:
  - ready = ~reset, so the sink never back-pressures after reset.
  - A beat is accepted iff valid&&ready. Non-accepted cycles change nothing.
- Position tracking:
  - x (10b) and y (9b) counters, no divider.
  - Per accepted in-frame beat, x increments; x wraps at VGA_WIDTH-1 to 0 and y increments.
- FSM states: WAIT_SOP, RECEIVE, RESYNC.
  - WAIT_SOP:
    - Beats without SOP are discarded silently.
    - An accepted SOP beat is pixel (0,0): latch cap=capture_en and go to RECEIVE, with x=1 next.
  - RECEIVE, accepted SOP beat: set err_sop_mid, restart the frame at (0,0) with the beat as pixel 0, and re-latch cap.
  - RECEIVE, accepted EOP beat with (x,y) != (639,479): set err_early_eop and go to WAIT_SOP. No frame_done, no count.
  - RECEIVE, accepted beat at (639,479):
    - With EOP: frame_count+1 and go to WAIT_SOP. If cap=1, frame_done pulses on the following cycle, together with the final write if any.
    - Without EOP: set err_missing_eop and go to RESYNC.
  - RESYNC: discard beats until an accepted EOP beat (go to WAIT_SOP) or an accepted SOP beat (treated as in WAIT_SOP, no error).
  - Simultaneous SOP+EOP on one beat: the SOP rule applies first; the beat is then also an early EOP → flag err_early_eop and return to WAIT_SOP.
- Decimation write:
  - For an accepted in-frame beat with cap=1, x[1:0]==0 and y[1:0]==0, the next cycle has wr_en=1, wr_addr=(y>>2)*160+(x>>2), wr_data=truncated channels.
  - Latency is 1 cycle. Writes are registered, so pixel 0 of a SOP beat is written.
  - Maximum wr_addr is 19199; wr_addr never exceeds it.
- Errors:
  - Error flags are sticky until err_clear.
  - err_clear has priority over a same-cycle set: the flag reads 0 next cycle, and a new error is lost only in that cycle.
- Reset mid-frame: everything returns to reset values; any partial frame is abandoned, and the next capture begins at the next SOP.
- frame_count wraps 65535→0.

Decomposition:
- Package vga_stream_pkg:
  - VGA_WIDTH, VGA_HEIGHT, SRC_WIDTH/SRC_HEIGHT (160/120), NumPixels, NumColourBits=12.
  - typedef cap_state_t {WAIT_SOP, RECEIVE, RESYNC}.
  - The function that truncates 30b pixels to 12b.
- Sub-module vga_pos_counter: x/y counters with clear, advance and wrap, plus outputs last_pixel and on_grid (x[1:0]==0&&y[1:0]==0).

Test Plan:
- Reset, then one clean frame (307200 beats, SOP on beat 0, EOP on the last, data=beat index pattern, capture_en=1) -> 19200 writes, addr 0..19199 in order, frame_done exactly once, frame_count=1, no errors.
- Same frame with valid toggled randomly 50% -> identical write sequence, and no writes on cycles where valid was low the cycle before.
- EOP on beat 1000 -> err_early_eop=1, no frame_done, frame_count unchanged; the next clean frame → count+1.
- Last beat lacks EOP, then 5 junk beats, then EOP, then a clean frame -> err_missing_eop=1, junk ignored, the clean frame captured fully.
- SOP at beat 5000 mid-frame, followed by a full frame -> err_sop_mid=1, restarted frame completes, wr_addr restarts at 0; err_clear → flag 0.
- capture_en=0 at SOP, toggled to 1 mid-frame -> no wr_en for the whole frame, frame_count+1, frame_done=0; reset asserted mid-frame → all outputs 0 the next cycle.
